// File: rtl/div_if.sv
// Request/response bundle between the execute-stage control and the iterative divider.
interface div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [1:0]       div_op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (output start, op1, op2, div_op, input busy, done, result, flags);
    modport slave  (input start, op1, op2, div_op, output busy, done, result, flags);
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the ALU division group (DIV/DIVU/REM/REMU).
// Signed operations are compiled in only when DIV_SIGNED_EN is defined.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   rem, rem_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rem_sel, rem_sel_n;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q, result_n;
    logic [3:0]       flags_q, flags_n;

    logic [WIDTH-1:0] op1_mag_c, op2_mag_c;
    logic             sovf_c;
    logic [WIDTH+1:0] rem_sh_c, diff_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
    logic is_signed_c, op1_neg_c, op2_neg_c;
    logic neg_q, neg_q_n, neg_r, neg_r_n;

    // Signed ops divide magnitudes; signs are restored in FIX.
    always_comb begin
        is_signed_c = ~bus.div_op[0];
        op1_neg_c   = is_signed_c & bus.op1[WIDTH-1];
        op2_neg_c   = is_signed_c & bus.op2[WIDTH-1];
        op1_mag_c   = op1_neg_c ? WIDTH'(-bus.op1) : bus.op1;
        op2_mag_c   = op2_neg_c ? WIDTH'(-bus.op2) : bus.op2;
        sovf_c      = is_signed_c && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
        quo_fix_c   = neg_q ? WIDTH'(-quo) : quo;
        rem_fix_c   = neg_r ? WIDTH'(-rem[WIDTH-1:0]) : rem[WIDTH-1:0];
    end
`else
    logic unused_c;
    assign unused_c = bus.div_op[0];

    always_comb begin
        op1_mag_c = bus.op1;
        op2_mag_c = bus.op2;
        sovf_c    = 1'b0;
        quo_fix_c = quo;
        rem_fix_c = rem[WIDTH-1:0];
    end
`endif

    // Trial subtract on the shifted partial remainder; the extra MSB carries the borrow.
    assign rem_sh_c = {rem, quo[WIDTH-1]};
    assign diff_c   = rem_sh_c - {2'b00, dvs};

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res, input logic ovf);
        return {res[WIDTH-1], (res == '0), 1'b0, ovf};
    endfunction

    // Next-state and datapath update.
    always_comb begin
        state_n   = state;
        rem_n     = rem;
        quo_n     = quo;
        dvs_n     = dvs;
        cnt_n     = cnt;
        rem_sel_n = rem_sel;
        result_n  = result_q;
        flags_n   = flags_q;
`ifdef DIV_SIGNED_EN
        neg_q_n   = neg_q;
        neg_r_n   = neg_r;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    rem_sel_n = bus.div_op[1];
                    rem_n     = '0;
                    quo_n     = op1_mag_c;
                    dvs_n     = op2_mag_c;
                    cnt_n     = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                    neg_q_n   = op1_neg_c ^ op2_neg_c;
                    neg_r_n   = op1_neg_c;
`endif
                    if (bus.op2 == '0) begin
                        result_n = bus.div_op[1] ? bus.op1 : '1;
                        flags_n  = mk_flags(result_n, 1'b1);
                        state_n  = DONE;
                    end else if (sovf_c) begin
                        result_n = bus.div_op[1] ? '0 : bus.op1;
                        flags_n  = mk_flags(result_n, 1'b1);
                        state_n  = DONE;
                    end else begin
                        state_n  = CALC;
                    end
                end
            end
            CALC: begin
                if (diff_c[WIDTH+1]) begin
                    rem_n = rem_sh_c[WIDTH:0];
                end else begin
                    rem_n = diff_c[WIDTH:0];
                end
                quo_n = {quo[WIDTH-2:0], ~diff_c[WIDTH+1]};
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                result_n = rem_sel ? rem_fix_c : quo_fix_c;
                flags_n  = mk_flags(result_n, 1'b0);
                state_n  = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            rem_sel  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvs      <= dvs_n;
            cnt      <= cnt_n;
            rem_sel  <= rem_sel_n;
            busy_q   <= (state_n != IDLE);
            done_q   <= (state_n == DONE);
            result_q <= result_n;
            flags_q  <= flags_n;
`ifdef DIV_SIGNED_EN
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus directed literal cases.
module tb_div_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) bus ();
    div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: {flags, result}; flags[0] (overflow) also marks the no-CALC special cases.
    function automatic logic [W+3:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] op);
        logic sgn;
        logic ovf;
        logic [W-1:0] r;
`ifdef DIV_SIGNED_EN
        sgn = ~op[0];
`else
        sgn = 1'b0;
`endif
        ovf = 1'b0;
        if (b == '0) begin
            r = op[1] ? a : '1;
            ovf = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = op[1] ? '0 : a;
            ovf = 1'b1;
        end else if (sgn) begin
            r = op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        end else begin
            r = op[1] ? (a % b) : (a / b);
        end
        return {r[W-1], (r == '0), 1'b0, ovf, r};
    endfunction

    // Cycle model: n counts clock edges; a request accepted at edge m_acc completes at m_done.
    int n = 0;
    int m_acc = -100;
    int m_done = -100;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] p_res = '0;
    logic [3:0]   m_flg = '0;
    logic [3:0]   p_flg = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc  = -100;
            m_done = -100;
            m_res  = '0;
            m_flg  = '0;
        end else begin
            n = n + 1;
            if (bus.start && n > m_done + 1) begin
                {p_flg, p_res} = ref_calc(bus.op1, bus.op2, bus.div_op);
                m_acc  = n;
                m_done = n + (p_flg[0] ? 0 : int'(W) + 1);
            end
            if (n == m_done) begin
                m_res = p_res;
                m_flg = p_flg;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",   W'(bus.busy),  W'(n >= m_acc && n <= m_done));
        chk("done",   W'(bus.done),  W'(n == m_done));
        chk("result", bus.result,    m_res);
        chk("flags",  W'(bus.flags), W'(m_flg));
    end

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one request at the current negedge and check latency, result and flags.
    task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic [W-1:0] exp_r,
                           input logic [3:0] exp_f, input int exp_lat, input int pulse_at);
        int lat;
        lat = 0;
        bus.start = 1'b1; bus.op1 = a; bus.op2 = b; bus.div_op = op;
        @(negedge clk);
        bus.start = 1'b0; bus.op1 = W'($urandom); bus.op2 = W'($urandom);
        for (int k = 1; k <= 100; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            bus.start = (k == pulse_at);
            if (k == pulse_at) begin
                bus.op1 = 32'd50; bus.op2 = 32'd5; bus.div_op = 2'b01;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({name, "_latency"}, W'(lat), W'(exp_lat));
        chk({name, "_result"}, bus.result, exp_r);
        chk({name, "_flags"}, W'(bus.flags), W'(exp_f));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.div_op = 2'b00;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_busy",   W'(bus.busy),  '0);
        chk("reset_done",   W'(bus.done),  '0);
        chk("reset_result", bus.result,    '0);
        chk("reset_flags",  W'(bus.flags), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_lit("divu_100_7", 32'd100, 32'd7, 2'b01, 32'd14, 4'b0000, W + 2, 0);
        run_lit("remu_100_7", 32'd100, 32'd7, 2'b11, 32'd2,  4'b0000, W + 2, 0);
        run_lit("divu_5_0",   32'd5,   32'd0, 2'b01, 32'hFFFF_FFFF, 4'b1001, 1, 0);
        run_lit("remu_5_0",   32'd5,   32'd0, 2'b11, 32'd5,  4'b0001, 1, 0);
`ifdef DIV_SIGNED_EN
        run_lit("div_m100_7", 32'hFFFF_FF9C, 32'd7, 2'b00, 32'hFFFF_FFF2, 4'b1000, W + 2, 0);
        run_lit("rem_m100_7", 32'hFFFF_FF9C, 32'd7, 2'b10, 32'hFFFF_FFFE, 4'b1000, W + 2, 0);
        run_lit("rem_100_m7", 32'd100, 32'hFFFF_FFF9, 2'b10, 32'd2, 4'b0000, W + 2, 0);
        run_lit("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 4'b1001, 1, 0);
        run_lit("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'd0, 4'b0101, 1, 0);
`endif
        run_lit("busy_start", 32'd1000, 32'd10, 2'b01, 32'd100, 4'b0000, W + 2, 10);

        // Abort mid-CALC with an asynchronous reset.
        bus.start = 1'b1; bus.op1 = 32'd1000; bus.op2 = 32'd3; bus.div_op = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",   W'(bus.busy),  '0);
        chk("abort_done",   W'(bus.done),  '0);
        chk("abort_result", bus.result,    '0);
        chk("abort_flags",  W'(bus.flags), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_lit("divu_9_3", 32'd9, 32'd3, 2'b01, 32'd3, 4'b0000, W + 2, 0);

        // Random traffic, including starts while busy and during done.
        repeat (1500) begin
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.op1    = rnd_op();
            bus.op2    = rnd_op();
            bus.div_op = 2'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
